// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM2x18 half-port among NREQ requesters,
// with fixed two-cycle read return and an optional zero-fill sweep after reset.
module bram_port_arbiter #(
    parameter int NREQ           = 4,
    parameter int DATA_W         = 18,
    parameter int IDX_W          = 10,
    parameter int ADDR_SHIFT     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     CLK_i,
    input  logic                     RST_i,
    input  logic [NREQ-1:0]          REQ_VALID_i,
    output logic [NREQ-1:0]          REQ_READY_o,
    input  logic [NREQ-1:0]          REQ_WE_i,
    input  logic [NREQ-1:0]          REQ_LOCK_i,
    input  logic [NREQ*IDX_W-1:0]    REQ_IDX_i,
    input  logic [NREQ*DATA_W-1:0]   REQ_WDATA_i,
    input  logic [NREQ*2-1:0]        REQ_BE_i,
    output logic [NREQ-1:0]          RSP_VALID_o,
    output logic [DATA_W-1:0]        RSP_DATA_o,
    output logic                     BUSY_o,
    output logic [13:0]              ADDR_o,
    output logic [17:0]              WDATA_o,
    output logic                     REN_o,
    output logic                     WEN_o,
    output logic [1:0]               BE_o,
    input  logic [17:0]              RDATA_i
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_k;
    logic [IDX_W-1:0]  w_k_next;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_next;

    logic [13:0]       r_addr;
    logic [17:0]       r_wdata;
    logic              r_ren;
    logic              r_wen;
    logic [1:0]        r_be;
    logic [NREQ-1:0]   r_tag1;
    logic [NREQ-1:0]   r_tag2;

    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_gidx;
    logic              w_accept;
    logic              w_sel_we;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_sel_be;
    logic [17:0]       w_pack_wdata;
    logic [13:0]       w_cmd_addr;
    logic [13:0]       w_clear_addr;
    logic              w_clearing;
    logic              w_unused_rdata;

    logic [IDX_W-1:0]  w_idx_arr   [NREQ];
    logic [DATA_W-1:0] w_wdata_arr [NREQ];
    logic [1:0]        w_be_arr    [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_idx_arr[gi]   = REQ_IDX_i[gi*IDX_W +: IDX_W];
            assign w_wdata_arr[gi] = REQ_WDATA_i[gi*DATA_W +: DATA_W];
            assign w_be_arr[gi]    = REQ_BE_i[gi*2 +: 2];
        end
    endgenerate

    // Scan from the priority pointer upward; the first valid requester wins.
    always_comb begin
        int               v_pos;
        logic [PTR_W-1:0] v_n;
        logic             v_found;
        w_grant = '0;
        w_gidx  = '0;
        v_found = 1'b0;
        v_pos   = 0;
        v_n     = '0;
        if (r_state == ST_RUN && !RST_i) begin
            for (int i = 0; i < NREQ; i++) begin
                v_pos = (int'(r_ptr) + i) % NREQ;
                v_n   = PTR_W'(v_pos);
                if (!v_found && REQ_VALID_i[v_n]) begin
                    v_found = 1'b1;
                    w_gidx  = v_n;
                end
            end
            if (v_found) begin
                w_grant[w_gidx] = 1'b1;
            end
        end
    end

    assign w_accept    = |w_grant;
    assign w_sel_we    = REQ_WE_i[w_gidx];
    assign w_sel_idx   = w_idx_arr[w_gidx];
    assign w_sel_wdata = w_wdata_arr[w_gidx];
    assign w_sel_be    = w_be_arr[w_gidx];

    assign w_cmd_addr   = 14'({{14{1'b0}}, w_sel_idx} << ADDR_SHIFT);
    assign w_clear_addr = 14'({{14{1'b0}}, r_k} << ADDR_SHIFT);

    // 9-bit words keep their ninth bit in the parity lane of the low byte.
    generate
        if (DATA_W == 9) begin : g_pack9
            assign w_pack_wdata = {1'b0, w_sel_wdata[8], 8'h00, w_sel_wdata[7:0]};
            assign RSP_DATA_o   = {RDATA_i[16], RDATA_i[7:0]};
        end else begin : g_pack_lsb
            assign w_pack_wdata = 18'(w_sel_wdata);
            assign RSP_DATA_o   = RDATA_i[DATA_W-1:0];
        end
    endgenerate

    assign w_unused_rdata = &{1'b0, RDATA_i};

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_k_next = r_k + 1'b1;
                if (&r_k) begin
                    w_state_next = ST_RUN;
                    w_k_next     = '0;
                end
            end
            default: begin
                if (w_accept) begin
                    if (REQ_LOCK_i[w_gidx]) begin
                        w_ptr_next = w_gidx;
                    end else if (w_gidx == PTR_W'(NREQ - 1)) begin
                        w_ptr_next = '0;
                    end else begin
                        w_ptr_next = w_gidx + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_k     <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_be    <= 2'b00;
            r_tag1  <= '0;
            r_tag2  <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_ptr   <= w_ptr_next;
            r_tag1  <= (w_accept && !w_sel_we) ? w_grant : '0;
            r_tag2  <= r_tag1;
            if (w_accept) begin
                r_addr <= w_cmd_addr;
                r_ren  <= !w_sel_we;
                r_wen  <= w_sel_we;
                r_be   <= w_sel_we ? w_sel_be : 2'b00;
                if (w_sel_we) begin
                    r_wdata <= w_pack_wdata;
                end
            end else begin
                r_ren <= 1'b0;
                r_wen <= 1'b0;
                r_be  <= 2'b00;
            end
        end
    end

    // The sweep drives the port directly so its first write lands in the
    // very first cycle after reset is released.
    assign w_clearing  = (r_state == ST_CLEAR) && !RST_i;
    assign BUSY_o      = (r_state == ST_CLEAR);
    assign ADDR_o      = w_clearing ? w_clear_addr : r_addr;
    assign WDATA_o     = w_clearing ? 18'h0 : r_wdata;
    assign REN_o       = w_clearing ? 1'b0 : r_ren;
    assign WEN_o       = w_clearing | r_wen;
    assign BE_o        = w_clearing ? 2'b11 : r_be;
    assign REQ_READY_o = w_grant;
    assign RSP_VALID_o = r_tag2;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a default 4x18 instance with clear sweep and a
// 2x9 instance without sweep, each attached to a small BRAM port model.
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic        rst;
    logic [3:0]  valid, ready, we, lock, rsp_valid;
    logic [39:0] req_idx;
    logic [71:0] req_wdata;
    logic [7:0]  req_be;
    logic [17:0] rsp_data;
    logic        busy, ren, wen;
    logic [13:0] addr;
    logic [17:0] wdata, rdata;
    logic [1:0]  be;

    bram_port_arbiter dut (
        .CLK_i(clk), .RST_i(rst),
        .REQ_VALID_i(valid), .REQ_READY_o(ready), .REQ_WE_i(we), .REQ_LOCK_i(lock),
        .REQ_IDX_i(req_idx), .REQ_WDATA_i(req_wdata), .REQ_BE_i(req_be),
        .RSP_VALID_o(rsp_valid), .RSP_DATA_o(rsp_data), .BUSY_o(busy),
        .ADDR_o(addr), .WDATA_o(wdata), .REN_o(ren), .WEN_o(wen), .BE_o(be),
        .RDATA_i(rdata)
    );

    logic [17:0] mem [1024];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 18'h3FFFF;
        end else begin
            if (wen) begin
                if (be[0]) begin
                    mem[addr[13:4]][7:0] <= wdata[7:0];
                    mem[addr[13:4]][16]  <= wdata[16];
                end
                if (be[1]) begin
                    mem[addr[13:4]][15:8] <= wdata[15:8];
                    mem[addr[13:4]][17]   <= wdata[17];
                end
            end
            if (ren) rdata <= mem[addr[13:4]];
        end
    end

    // ---------------- 9-bit instance ----------------
    logic        rst9;
    logic [1:0]  valid9, ready9, we9, lock9, rsp_valid9;
    logic [7:0]  req_idx9;
    logic [17:0] req_wdata9;
    logic [3:0]  req_be9;
    logic [8:0]  rsp_data9;
    logic        busy9, ren9, wen9;
    logic [13:0] addr9;
    logic [17:0] wdata9, rdata9;
    logic [1:0]  be9;

    bram_port_arbiter #(
        .NREQ(2), .DATA_W(9), .IDX_W(4), .ADDR_SHIFT(3), .CLEAR_ON_RESET(0)
    ) dut9 (
        .CLK_i(clk), .RST_i(rst9),
        .REQ_VALID_i(valid9), .REQ_READY_o(ready9), .REQ_WE_i(we9), .REQ_LOCK_i(lock9),
        .REQ_IDX_i(req_idx9), .REQ_WDATA_i(req_wdata9), .REQ_BE_i(req_be9),
        .RSP_VALID_o(rsp_valid9), .RSP_DATA_o(rsp_data9), .BUSY_o(busy9),
        .ADDR_o(addr9), .WDATA_o(wdata9), .REN_o(ren9), .WEN_o(wen9), .BE_o(be9),
        .RDATA_i(rdata9)
    );

    logic [17:0] mem9 [16];
    always @(posedge clk) begin
        if (rst9) begin
            for (int i = 0; i < 16; i++) mem9[i] <= 18'h2AAAA;
        end else begin
            if (wen9) begin
                if (be9[0]) begin
                    mem9[addr9[6:3]][7:0] <= wdata9[7:0];
                    mem9[addr9[6:3]][16]  <= wdata9[16];
                end
                if (be9[1]) begin
                    mem9[addr9[6:3]][15:8] <= wdata9[15:8];
                    mem9[addr9[6:3]][17]   <= wdata9[17];
                end
            end
            if (ren9) rdata9 <= mem9[addr9[6:3]];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] we;
        logic [3:0] lock;
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        logic       exp_ren;
        logic       exp_wen;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "time limit reached");
    end

    initial begin
        int bad_busy, bad_wen, bad_addr, bad_ready, busy_cnt, rsp_seen;

        vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 1'b0, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0};
        vecs[9]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 1'b1, 1'b0};
        vecs[11] = '{4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 1'b1, 1'b0};
        vecs[12] = '{4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 1'b1, 1'b0};
        vecs[13] = '{4'b1100, 4'b0100, 4'b0000, 4'b0100, 4'b1000, 1'b1, 1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

        rst = 1'b1; rst9 = 1'b1;
        valid = 4'b1111; we = '0; lock = '0;
        req_idx   = {10'd13, 10'd12, 10'd11, 10'd10};
        req_wdata = {18'h00033, 18'h00022, 18'h00011, 18'h00000};
        req_be    = 8'hFF;
        valid9 = '0; we9 = '0; lock9 = '0; req_idx9 = '0; req_wdata9 = '0; req_be9 = '0;

        // Reset state, with every requester asking.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_ren", 32'(ren), 32'h0);
        check("reset_wen", 32'(wen), 32'h0);
        check("reset_be", 32'(be), 32'h0);
        check("reset_addr", 32'(addr), 32'h0);
        check("reset_wdata", 32'(wdata), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);

        // Zero-fill sweep.
        @(posedge clk); #1;
        rst = 1'b0;
        bad_busy = 0; bad_wen = 0; bad_addr = 0; bad_ready = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (wen !== 1'b1 || be !== 2'b11 || wdata !== 18'h0) bad_wen++;
            if (addr !== 14'(k * 16)) bad_addr++;
            if (ready !== 4'b0000) bad_ready++;
            next_cycle();
        end
        check("sweep_busy_bad_cycles", 32'(bad_busy), 32'h0);
        check("sweep_write_bad_cycles", 32'(bad_wen), 32'h0);
        check("sweep_addr_bad_cycles", 32'(bad_addr), 32'h0);
        check("sweep_ready_bad_cycles", 32'(bad_ready), 32'h0);

        // Arbitration table, starting in the first RUN cycle.
        for (int r = 0; r < 17; r++) begin
            valid = vecs[r].valid;
            we    = vecs[r].we;
            lock  = vecs[r].lock;
            @(negedge clk);
            if (r == 0) check("busy_after_sweep", 32'(busy), 32'h0);
            check($sformatf("vec%0d_ready", r), 32'(ready), 32'(vecs[r].exp_ready));
            check($sformatf("vec%0d_rsp_valid", r), 32'(rsp_valid), 32'(vecs[r].exp_rsp));
            check($sformatf("vec%0d_ren", r), 32'(ren), 32'(vecs[r].exp_ren));
            check($sformatf("vec%0d_wen", r), 32'(wen), 32'(vecs[r].exp_wen));
            if (vecs[r].exp_rsp != 4'b0000)
                check($sformatf("vec%0d_rsp_data_cleared", r), 32'(rsp_data), 32'h0);
            next_cycle();
        end

        // Write from requester 2, read-back from requester 0.
        lock = '0;
        req_idx[20 +: 10]   = 10'd5;
        req_wdata[36 +: 18] = 18'h2A5A5;
        req_be[4 +: 2]      = 2'b11;
        req_idx[0 +: 10]    = 10'd5;
        valid = 4'b0100; we = 4'b0100;
        @(negedge clk);
        check("wr_ready", 32'(ready), 32'h4);
        next_cycle();
        valid = 4'b0001; we = 4'b0000;
        @(negedge clk);
        check("rd_ready", 32'(ready), 32'h1);
        check("wr_cmd_addr", 32'(addr), 32'd80);
        check("wr_cmd_wen", 32'({wen, ren}), 32'h2);
        check("wr_cmd_wdata", 32'(wdata), 32'h2A5A5);
        check("wr_cmd_be", 32'(be), 32'h3);
        next_cycle();
        valid = 4'b0000;
        @(negedge clk);
        check("rd_cmd_addr", 32'(addr), 32'd80);
        check("rd_cmd_ren", 32'({wen, ren}), 32'h1);
        check("rd_cmd_be", 32'(be), 32'h0);
        next_cycle();
        @(negedge clk);
        check("raw_rsp_valid", 32'(rsp_valid), 32'h1);
        check("raw_rsp_data", 32'(rsp_data), 32'h2A5A5);
        next_cycle();

        // Reset one cycle after a read accept: the response must vanish.
        req_idx[10 +: 10] = 10'd5;
        valid = 4'b0010;
        @(negedge clk);
        check("pre_reset_read_ready", 32'(ready), 32'h2);
        next_cycle();
        valid = 4'b0000;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        busy_cnt = 0; rsp_seen = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) rsp_seen++;
            if (busy !== 1'b1) break;
            busy_cnt++;
            if (busy_cnt == 1) begin
                check("restart_addr0", 32'(addr), 32'h0);
                check("restart_wen", 32'(wen), 32'h1);
            end
            if (busy_cnt == 2) check("restart_addr1", 32'(addr), 32'd16);
            next_cycle();
        end
        check("reset_rsp_pulses", 32'(rsp_seen), 32'h0);
        check("restart_sweep_len", 32'(busy_cnt), 32'd1024);

        // 9-bit packing on the second instance, no sweep.
        next_cycle();
        rst9 = 1'b0;
        req_idx9[0 +: 4]   = 4'd7;
        req_wdata9[0 +: 9] = 9'h1C3;
        req_be9[0 +: 2]    = 2'b11;
        req_idx9[4 +: 4]   = 4'd7;
        valid9 = 2'b01; we9 = 2'b01;
        @(negedge clk);
        check("w9_first_cycle_ready", 32'(ready9), 32'h1);
        check("w9_busy", 32'(busy9), 32'h0);
        next_cycle();
        valid9 = 2'b10; we9 = 2'b00;
        @(negedge clk);
        check("w9_read_ready", 32'(ready9), 32'h2);
        check("w9_wdata", 32'(wdata9), 32'h100C3);
        check("w9_addr", 32'(addr9), 32'd56);
        check("w9_wen", 32'(wen9), 32'h1);
        next_cycle();
        valid9 = 2'b00;
        @(negedge clk);
        check("r9_cmd", 32'({addr9, ren9}), 32'({14'd56, 1'b1}));
        next_cycle();
        @(negedge clk);
        check("r9_rsp_valid", 32'(rsp_valid9), 32'h2);
        check("r9_rsp_data", 32'(rsp_data9), 32'h1C3);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
